player_state_fsm: RTL

Per-player character state machine for the footsies game. It turns synchronized button inputs into the 3-bit character state consumed by the sprite renderer, which derives position and colour from it. It also sequences attack phases with frame-counted durations. It sits between the board button inputs and the renderer, one instance per player, and advances only on the 60 Hz frame tick.

---
 rtl/footsies_pkg.sv | 29 ++
 rtl/button_sync.sv | 46 ++++
 rtl/player_state_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/footsies_pkg.sv
// Shared definitions for the footsies player logic: character state encoding
// (fixed values, the sprite renderer decodes them) and default frame counts.
package footsies_pkg;

  typedef enum logic [2:0] {
    S_IDLE            = 3'd0,
    S_BACKWARD        = 3'd1,
    S_FORWARD         = 3'd2,
    S_ATTACK_START    = 3'd3,
    S_ATTACK_ACTIVE   = 3'd4,
    S_ATTACK_RECOVERY = 3'd5
  } state_t;

  localparam int COUNT_W                 = 6;
  localparam int DEFAULT_START_FRAMES    = 5;
  localparam int DEFAULT_ACTIVE_FRAMES   = 2;
  localparam int DEFAULT_RECOVERY_FRAMES = 16;

  // fwd and back arrive already made mutually exclusive
  function automatic state_t move_decode(input logic fwd, input logic back);
    if (fwd) begin
      return S_FORWARD;
    end else if (back) begin
      return S_BACKWARD;
    end
    return S_IDLE;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for one raw button, with an optional rising-edge pulse
// taken from the synchronized level (EDGE_EN=0 drives rise low).
module button_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= sync_q;
        end
      end

      assign rise = sync_q & ~prev_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/player_state_fsm.sv
// Per-player character state machine, advancing once per frame_tick.
// Define ATTACK_BUFFER_EN to let one attack press during recovery chain a new attack.
module player_state_fsm
  import footsies_pkg::*;
#(
  parameter int START_FRAMES    = DEFAULT_START_FRAMES,
  parameter int ACTIVE_FRAMES   = DEFAULT_ACTIVE_FRAMES,
  parameter int RECOVERY_FRAMES = DEFAULT_RECOVERY_FRAMES,
  parameter int FACING_RIGHT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       frame_tick,
  output logic [2:0] state,
  output logic       hitbox_en,
  output logic       busy
);

  localparam logic [COUNT_W-1:0] START_LOAD    = COUNT_W'(START_FRAMES - 1);
  localparam logic [COUNT_W-1:0] ACTIVE_LOAD   = COUNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [COUNT_W-1:0] RECOVERY_LOAD = COUNT_W'(RECOVERY_FRAMES - 1);

  logic left_s;
  logic right_s;
  logic attack_rise;
  logic left_rise_unused;
  logic right_rise_unused;
  logic attack_level_unused;

  button_sync #(.EDGE_EN(1'b0)) u_sync_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (btn_left),
    .sync_out (left_s),
    .rise     (left_rise_unused)
  );

  button_sync #(.EDGE_EN(1'b0)) u_sync_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (btn_right),
    .sync_out (right_s),
    .rise     (right_rise_unused)
  );

  button_sync #(.EDGE_EN(1'b1)) u_sync_attack (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (btn_attack),
    .sync_out (attack_level_unused),
    .rise     (attack_rise)
  );

  logic fwd_raw;
  logic back_raw;
  logic fwd;
  logic back;

  assign fwd_raw = (FACING_RIGHT != 0) ? right_s : left_s;
  assign back_raw = (FACING_RIGHT != 0) ? left_s : right_s;
  assign fwd  = fwd_raw & ~back_raw;
  assign back = back_raw & ~fwd_raw;

  state_t             state_q;
  state_t             state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               attack_req;
  logic               buffered;

  // Every tick consumes the request; a new edge in the same cycle survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attack_req <= 1'b0;
    end else if (attack_rise) begin
      attack_req <= 1'b1;
    end else if (frame_tick) begin
      attack_req <= 1'b0;
    end
  end

`ifdef ATTACK_BUFFER_EN
  logic buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= 1'b0;
    end else if (frame_tick && state_q == S_ATTACK_RECOVERY && count_q == '0) begin
      buf_q <= 1'b0;
    end else if (attack_rise && state_q == S_ATTACK_RECOVERY) begin
      buf_q <= 1'b1;
    end
  end

  assign buffered = buf_q;
`else
  assign buffered = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_BACKWARD, S_FORWARD: begin
        if (attack_req) begin
          state_d = S_ATTACK_START;
          count_d = START_LOAD;
        end else begin
          state_d = move_decode(fwd, back);
        end
      end
      S_ATTACK_START: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          state_d = S_ATTACK_ACTIVE;
          count_d = ACTIVE_LOAD;
        end
      end
      S_ATTACK_ACTIVE: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          state_d = S_ATTACK_RECOVERY;
          count_d = RECOVERY_LOAD;
        end
      end
      S_ATTACK_RECOVERY: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (buffered) begin
          state_d = S_ATTACK_START;
          count_d = START_LOAD;
        end else begin
          state_d = move_decode(fwd, back);
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Flags are decoded from the next state so they switch on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      hitbox_en <= 1'b0;
      busy      <= 1'b0;
    end else if (frame_tick) begin
      state_q   <= state_d;
      count_q   <= count_d;
      hitbox_en <= (state_d == S_ATTACK_ACTIVE);
      busy      <= (state_d == S_ATTACK_START) || (state_d == S_ATTACK_ACTIVE) ||
                   (state_d == S_ATTACK_RECOVERY);
    end
  end

  assign state = state_q;

endmodule
